// File: rtl/e_muldiv_unit_pkg.sv
// MDU shared constants: op codes, op width and default latencies.
`default_nettype none

package e_muldiv_unit_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic md_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [MDU_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/e_muldiv_unit_compute.sv
// Combinational multiply/divide datapath producing {hi, lo} from latched operands.
`default_nettype none

module muldiv_compute
  import e_muldiv_unit_pkg::*;
(
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  input  logic [MDU_OP_W-1:0] op,
  output logic [63:0]         result,
  output logic                div_by_zero
);

  logic        is_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic [31:0] quot;
  logic [31:0] rem;

  assign is_signed = md_is_signed(op);

  // Low 64 bits of the extended product are the exact 32x32 result for both signednesses.
  assign a_ext   = {{32{is_signed & a[31]}}, a};
  assign b_ext   = {{32{is_signed & b[31]}}, b};
  assign product = a_ext * b_ext;

  // Sign-magnitude division; 0x80000000 / -1 naturally wraps back to 0x80000000 rem 0.
  assign a_neg   = is_signed & a[31];
  assign b_neg   = is_signed & b[31];
  assign a_mag   = a_neg ? (32'd0 - a) : a;
  assign b_mag   = b_neg ? (32'd0 - b) : b;
  assign divisor = (b == 32'd0) ? 32'd1 : b_mag;
  assign uquot   = a_mag / divisor;
  assign urem    = a_mag % divisor;
  assign quot    = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
  assign rem     = a_neg ? (32'd0 - urem) : urem;

  assign result      = md_is_div(op) ? {rem, quot} : product;
  assign div_by_zero = md_is_div(op) && (b == 32'd0);

endmodule

`default_nettype wire

// File: rtl/e_muldiv_unit.sv
// Execute-stage multi-cycle multiply/divide unit owning the HI/LO registers.
`default_nettype none

module e_muldiv_unit
  import e_muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic                busy,
  output logic [31:0]         hi,
  output logic [31:0]         lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] C_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q,  cnt_d;
  logic [31:0]         a_q,    a_d;
  logic [31:0]         b_q,    b_d;
  logic [MDU_OP_W-1:0] op_q,   op_d;
  logic [31:0]         hi_q,   hi_d;
  logic [31:0]         lo_q,   lo_d;

  logic [63:0]         result;
  logic                div_by_zero;

  muldiv_compute u_compute (
    .a           (a_q),
    .b           (b_q),
    .op          (op_q),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (!busy_q) begin
      if (start) begin
        case (op)
          MD_MULT, MD_MULTU: begin
            a_d    = a;
            b_d    = b;
            op_d   = op;
            cnt_d  = C_MULT;
            busy_d = 1'b1;
          end
          MD_DIV, MD_DIVU: begin
            a_d    = a;
            b_d    = b;
            op_d   = op;
            cnt_d  = C_DIV;
            busy_d = 1'b1;
          end
          MD_MTHI: hi_d = a;
          MD_MTLO: lo_d = a;
          default: ;
        endcase
      end
    end else begin
      // New starts are ignored here; completion happens on the 1 -> 0 counter edge.
      cnt_d = cnt_q - C_ONE;
      if (cnt_q == C_ONE) begin
        busy_d = 1'b0;
        if (!div_by_zero) begin
          hi_d = result[63:32];
          lo_d = result[31:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: doc/e_muldiv_unit.md
Name: e_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers, in the Execute stage beside the ALU.
- Consumes operands and decoded op from the D2E pipeline register.
- Drives HI/LO read data to the E-stage result mux.
- Drives busy to the hazard unit, which freezes I2D/PC and sets NOP into D2E while any HI/LO-touching instruction waits in Decode.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, busy duration for DIV/DIVU (must be >= 1).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  E-stage instruction is a valid MDU op this cycle.
- op  input  3  MDU operation code (shared constants, below).
- a  input  32  operand rs (forwarded D1).
- b  input  32  operand rt (forwarded D2).
- busy  output  1  operation in flight; registered.
- hi  output  32  HI register; registered.
- lo  output  32  LO register; registered.

Behaviour:
- Reset (reset == 0, asynchronous): hi = 0, lo = 0, busy = 0, counter = 0, operand latches = 0. Any in-flight op is abandoned with no HI/LO write.
- Op codes:
  - MD_MULT = 0: signed 32x32 -> 64.
  - MD_MULTU = 1: unsigned 32x32 -> 64.
  - MD_DIV = 2: signed.
  - MD_DIVU = 3: unsigned.
  - MD_MTHI = 4, MD_MTLO = 5.
  - Codes 6 and 7 are no-ops.
- start is sampled on a rising edge only when busy == 0. start while busy == 1 is ignored; the hazard unit guarantees this cannot occur, and the bench checks that the unit ignores it.
- MTHI/MTLO: hi (or lo) <= a at the sampling edge. Visible the next cycle. busy stays 0.
- MULT/MULTU at edge t:
  - Latch a, b, and op.
  - Load counter = MULT_CYCLES; busy = 1 from edge t.
  - Counter decrements each edge.
  - At the edge where the counter goes 1 -> 0: {hi, lo} <= 64-bit product and busy <= 0, on the same edge.
  - busy is therefore high for exactly MULT_CYCLES cycles; the result is readable in the cycle busy first reads 0.
- DIV/DIVU: same as multiply, with counter = DIV_CYCLES.
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0.
  - Divide by zero: busy still runs DIV_CYCLES; hi/lo are left unchanged at completion.
- Arithmetic is computed from the latched operands, never the live a/b, so upstream changes during busy have no effect.
- Simultaneous completion and start: start is sampled only when busy == 0, so a new op can begin on the edge after busy falls, never on the completion edge itself.
- hi/lo change only at: the MTHI/MTLO sampling edge, the completion edge, or reset.

Decomposition:
- Add to def.v:
  - MD_* op constants, 3 bits.
  - MDU_OP_W = 3.
  - MULT_CYCLES_DEF and DIV_CYCLES_DEF defaults.
- One sub-module, muldiv_compute: purely combinational. Takes latched a, b, op and returns a 64-bit {hi, lo} result plus a div_by_zero flag.
- The counter, busy logic, and HI/LO registers stay in e_muldiv_unit.

Test Plan:
- Reset with reset = 0 mid-DIV (3 cycles after start) -> busy = 0, hi = lo = 0 immediately (asynchronous). After release, no write occurs.
- MULT a = 0xFFFFFFFD (-3), b = 5 -> busy high 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. MULTU a = 0xFFFFFFFF, b = 2 -> hi = 0x00000001, lo = 0xFFFFFFFE.
- DIV a = 0xFFFFFFF9 (-7), b = 2 -> busy 10 cycles, then lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- MTHI a = 0x12345678, then MTLO a = 0x9ABCDEF0 -> hi/lo updated one edge each, busy never asserted.
- DIVU b = 0 after hi = 0x11, lo = 0x22 -> busy 10 cycles, hi/lo remain 0x11/0x22.
- MULT started, then start = 1 with MTLO every cycle during busy, and a/b toggled -> lo is not written by MTLO, and the result equals the product of the original latched operands.
